muldiv_unit: RTL and testbench

//  Execute-stage HI/LO unit, fed directly by the decode stage's control word.

---
 rtl/mycpu_pkg.sv | 16 +
 rtl/div_iter.sv | 47 ++++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: HI/LO unit state encoding, ALU funct codes and a
// sign-magnitude helper used by the multiply/divide datapath.
package mycpu_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_t;

  localparam logic [3:0] ALU_MULT  = 4'b1011;
  localparam logic [3:0] ALU_MULTU = 4'b1100;
  localparam logic [3:0] ALU_DIV   = 4'b1101;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// quotient/remainder show the result of the step taken in the current cycle.
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        step,
  input  logic        last,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        fits;

  // The partial remainder is always below the divisor, so a set bit 32 of
  // the difference can only mean a borrow.
  always_comb begin
    trial     = {rem, quo[31]};
    diff      = trial - {1'b0, dsr};
    fits      = ~diff[32];
    quotient  = {quo[30:0], fits};
    remainder = fits ? diff[31:0] : trial[31:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (step && !last) begin
      quo <= quotient;
      rem <= remainder;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage HI/LO unit: MULT/MULTU/DIV/DIVU, MTHI/MTLO, owns HI and LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle registered multiplier.
module muldiv_unit
  import mycpu_pkg::*;
#(
  parameter int DIV_STEPS = 32
`ifndef MULDIV_FAST_MUL_EN
  , parameter int MUL_STEPS = 32
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [3:0]  funct_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  muldiv_state_t state;
  logic [5:0]    counter;
  logic [31:0]   hi_q, lo_q;
  logic          neg_q, neg_r;
  logic          is_md, is_div, is_signed;
  logic [31:0]   a_mag, b_mag;
  logic          div_last, mul_last;
  logic [31:0]   div_q, div_r, quo_fix, rem_fix;
  logic [63:0]   mul_raw, mul_res;
  logic          load_mul;

  always_comb begin
    is_md     = start_i & hi_we_i & lo_we_i &
                (funct_i inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU});
    is_div    = (funct_i == ALU_DIV) | (funct_i == ALU_DIVU);
    is_signed = (funct_i == ALU_MULT) | (funct_i == ALU_DIV);
    a_mag     = mag32(a_i, is_signed);
    b_mag     = mag32(b_i, is_signed);
    div_last  = (counter == 6'(DIV_STEPS - 1));
    quo_fix   = neg_q ? -div_q : div_q;
    rem_fix   = neg_r ? -div_r : div_r;
    mul_res   = neg_q ? -mul_raw : mul_raw;
    load_mul  = (state == IDLE) & is_md & ~is_div & ~flush_i;
  end

  assign busy_o = (state == MUL) | (state == DIV) | ((state == IDLE) & is_md & ~flush_i);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  div_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .load      ((state == IDLE) & is_md & is_div & ~flush_i),
    .step      (state == DIV),
    .last      (div_last),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_q),
    .remainder (div_r)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [31:0] mul_a, mul_b;

  assign mul_raw  = {32'b0, mul_a} * {32'b0, mul_b};
  assign mul_last = 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (load_mul) begin
      mul_a <= a_mag;
      mul_b <= b_mag;
    end
  end
`else
  // Shift-add: upper half accumulates, multiplier bits retire out of the lower half.
  logic [31:0] mcand;
  logic [63:0] prod;
  logic [32:0] mul_sum;

  always_comb begin
    mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
    mul_raw  = {mul_sum, prod[31:1]};
    mul_last = (counter == 6'(MUL_STEPS - 1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand <= '0;
      prod  <= '0;
    end else if (load_mul) begin
      mcand <= a_mag;
      prod  <= {32'b0, b_mag};
    end else if (state == MUL) begin
      prod  <= mul_raw;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      counter <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            neg_q   <= is_signed & (a_i[31] ^ b_i[31]);
            neg_r   <= is_signed & a_i[31];
            counter <= '0;
            if (!is_div)          state <= MUL;
            else if (b_i == '0)   state <= DONE;
            else                  state <= DIV;
          end else if (start_i && (hi_we_i ^ lo_we_i)) begin
            if (hi_we_i) hi_q <= a_i;
            else         lo_q <= a_i;
          end
        end
        MUL: begin
          if (mul_last) begin
            {hi_q, lo_q} <= mul_res;
            state        <= DONE;
          end else begin
            counter <= counter + 6'd1;
          end
        end
        DIV: begin
          if (div_last) begin
            lo_q  <= quo_fix;
            hi_q  <= rem_fix;
            state <= DONE;
          end else begin
            counter <= counter + 6'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an expected-result queue.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [3:0]  funct;
  logic        hi_we, lo_we;
  logic [31:0] a, b;
  logic        flush;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] F_MULT = 4'b1011, F_MULTU = 4'b1100,
                         F_DIV = 4'b1101, F_DIVU = 4'b1110, F_MOVE = 4'b0000;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_CYC = 2;
`else
  localparam int MUL_CYC = 33;
`endif
  localparam int DIV_CYC = 33;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (start),
    .funct_i (funct),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .a_i     (a),
    .b_i     (b),
    .flush_i (flush),
    .busy_o  (busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] h, input logic [31:0] l,
                          input int cyc);
    exp_t e;
    e.tag = tag; e.hi = h; e.lo = l; e.cyc = cyc;
    sb.push_back(e);
    m_hi = h;
    m_lo = l;
  endtask

  task automatic idle_inputs();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; funct = F_MOVE; flush = 1'b0;
  endtask

  // Issue an op, hold start through the stall and the DONE cycle, then compare.
  task automatic run_md(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; funct = f; a = av; b = bv;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    e = sb.pop_front();
    check({e.tag, " busy cycles"}, 64'(n), 64'(e.cyc));
    check({e.tag, " hi"}, hi, e.hi);
    check({e.tag, " lo"}, lo, e.lo);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check({e.tag, " no restart from DONE"}, busy, 1'b0);
    check({e.tag, " hi held"}, hi, e.hi);
    check({e.tag, " lo held"}, lo, e.lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    a = '0; b = '0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    resetn = 1'b1;

    // MTHI then MTLO back-to-back
    @(posedge clk); #1;
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b0; funct = F_MOVE; a = 32'h1234;
    @(negedge clk);
    check("mthi busy", busy, 1'b0);
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; a = 32'h5678;
    @(negedge clk);
    check("mtlo busy", busy, 1'b0);
    check("mthi hi", hi, 32'h1234);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("mtlo lo", lo, 32'h5678);
    check("mtlo hi kept", hi, 32'h1234);
    m_hi = 32'h1234; m_lo = 32'h5678;

    push_exp("divu 100/7", 32'd2, 32'd14, DIV_CYC);
    run_md(F_DIVU, 32'd100, 32'd7);
    push_exp("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYC);
    run_md(F_DIV, 32'hFFFF_FFF9, 32'd2);
    push_exp("div 7/-2", 32'd1, 32'hFFFF_FFFD, DIV_CYC);
    run_md(F_DIV, 32'd7, 32'hFFFF_FFFE);
    push_exp("divu ffffffff/16", 32'hF, 32'h0FFF_FFFF, DIV_CYC);
    run_md(F_DIVU, 32'hFFFF_FFFF, 32'h10);
    push_exp("mult -1*-1", 32'h0, 32'h1, MUL_CYC);
    run_md(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_exp("multu max*max", 32'hFFFF_FFFE, 32'h1, MUL_CYC);
    run_md(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_exp("mult -3*5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_CYC);
    run_md(F_MULT, 32'hFFFF_FFFD, 32'd5);
    push_exp("div min/-1", 32'h0, 32'h8000_0000, DIV_CYC);
    run_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    push_exp("div by zero", m_hi, m_lo, 1);
    run_md(F_DIV, 32'd55, 32'd0);

    // flush together with a move: no write
    @(posedge clk); #1;
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b0; funct = F_MOVE; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("flush+move hi", hi, m_hi);

    // flush together with a DIV: never starts
    @(posedge clk); #1;
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; funct = F_DIV; a = 32'd9; b = 32'd2; flush = 1'b1;
    @(negedge clk);
    check("flush+div busy", busy, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("flush+div no start", busy, 1'b0);

    // flush at cycle 10 of a DIV
    @(posedge clk); #1;
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; funct = F_DIV; a = 32'd1000; b = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush cycle10 busy", busy, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("flush cycle11 busy", busy, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("flush hi kept", hi, m_hi);
    check("flush lo kept", lo, m_lo);
    check("flush stays idle", busy, 1'b0);

    // reset at cycle 5 of a DIVU
    @(posedge clk); #1;
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; funct = F_DIVU; a = 32'd1000; b = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    idle_inputs();
    resetn = 1'b0;
    #1;
    check("midop reset hi", hi, 32'h0);
    check("midop reset lo", lo, 32'h0);
    check("midop reset busy", busy, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    m_hi = '0; m_lo = '0;
    push_exp("divu after reset", 32'd2, 32'd8, DIV_CYC);
    run_md(F_DIVU, 32'd50, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
